// File: rtl/pkg_dtypes.sv
// Shared data types for the execution unit and its interconnect channels.
package pkg_dtypes;

  typedef logic [7:0]  type_exec_unit_addr;
  typedef logic [15:0] type_exec_unit_data;

  // Packet returned to the interconnect on the TX channel.
  typedef struct packed {
    logic               valid;
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_icon_tx_channel;

  // One slot of the transmit result buffer.
  typedef struct packed {
    logic               occ;
    type_exec_unit_addr addr;
    type_exec_unit_data data;
  } type_txbuf_entry;

  localparam int TXBUF_DEF_IDX_BITS = 2;

endpackage

// File: rtl/eu_txbuf_chk.sv
// Simulation checker for the TX buffer occupancy count.
module eu_txbuf_chk #(
  parameter int NUM_IDX_BITS = 2
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  alu_wr_ready,
  input logic [NUM_IDX_BITS:0] num_entries
);

  localparam logic [NUM_IDX_BITS:0] FULL_CNT = (NUM_IDX_BITS+1)'(2**NUM_IDX_BITS);

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    num_entries <= FULL_CNT);

  a_ready_consistent: assert property (@(posedge clk) disable iff (reset)
    alu_wr_ready == (num_entries != FULL_CNT));

endmodule

// File: rtl/eu_txbuf_lookup.sv
// Combinational lookup for the TX buffer: read CAM, write CAM, lowest-free encoder.
module eu_txbuf_lookup
  import pkg_dtypes::*;
#(
  parameter int NUM_IDX_BITS = TXBUF_DEF_IDX_BITS
) (
  input  type_txbuf_entry [2**NUM_IDX_BITS-1:0] entries,
  input  type_exec_unit_addr                    rd_addr,
  input  type_exec_unit_addr                    wr_addr,
  output logic                                  rd_hit,
  output logic [2**NUM_IDX_BITS-1:0]            rd_onehot,
  output logic [NUM_IDX_BITS-1:0]               rd_idx,
  output logic                                  wr_hit,
  output logic [2**NUM_IDX_BITS-1:0]            wr_onehot,
  output logic [NUM_IDX_BITS-1:0]               wr_idx,
  output logic                                  free_any,
  output logic [NUM_IDX_BITS-1:0]               free_idx
);

  localparam int NUM_ENTRIES = 2**NUM_IDX_BITS;

  // Match both addresses against occupied slots; at most one slot can match,
  // so OR-ing the indices of matching slots yields the encoded index.
  always_comb begin
    rd_onehot = '0;
    wr_onehot = '0;
    rd_idx    = '0;
    wr_idx    = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      rd_onehot[i] = entries[i].occ && (entries[i].addr == rd_addr);
      wr_onehot[i] = entries[i].occ && (entries[i].addr == wr_addr);
      rd_idx       = rd_idx | (rd_onehot[i] ? NUM_IDX_BITS'(i) : NUM_IDX_BITS'(0));
      wr_idx       = wr_idx | (wr_onehot[i] ? NUM_IDX_BITS'(i) : NUM_IDX_BITS'(0));
    end
    rd_hit = |rd_onehot;
    wr_hit = |wr_onehot;
  end

  // Lowest-index free slot: scan downwards so the lowest free index wins.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      free_any = free_any | ~entries[i].occ;
      free_idx = (!entries[i].occ) ? NUM_IDX_BITS'(i) : free_idx;
    end
  end

endmodule

// File: rtl/eu_txbuf.sv
// Transmit result buffer: ALU pushes tagged results, interconnect pulls them once by address.
module eu_txbuf
  import pkg_dtypes::*;
#(
  parameter int NUM_IDX_BITS = TXBUF_DEF_IDX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_wr_valid,
  input  type_exec_unit_addr    alu_wr_addr,
  input  type_exec_unit_data    alu_wr_data,
  output logic                  alu_wr_ready,
  input  logic                  icon_req_valid,
  input  type_exec_unit_addr    icon_req_addr,
  output type_icon_tx_channel   out_pkt,
  output logic [NUM_IDX_BITS:0] num_entries
);

  localparam int                  NUM_ENTRIES = 2**NUM_IDX_BITS;
  localparam logic [NUM_IDX_BITS:0] FULL_CNT  = (NUM_IDX_BITS+1)'(NUM_ENTRIES);

  type_txbuf_entry [NUM_ENTRIES-1:0] entries_q, entries_d;
  logic [NUM_IDX_BITS:0]             count_q, count_d;
  type_icon_tx_channel               out_pkt_q, out_pkt_d;

  logic                    rd_hit_s, wr_hit_s, free_any_s;
  logic [NUM_ENTRIES-1:0]  rd_onehot_s, wr_onehot_s;
  logic [NUM_IDX_BITS-1:0] rd_idx_s, wr_idx_s, free_idx_s;
  logic                    wr_fire_s, rd_fire_s, alloc_s, same_addr_s;

  eu_txbuf_lookup #(.NUM_IDX_BITS(NUM_IDX_BITS)) u_lookup (
    .entries   (entries_q),
    .rd_addr   (icon_req_addr),
    .wr_addr   (alu_wr_addr),
    .rd_hit    (rd_hit_s),
    .rd_onehot (rd_onehot_s),
    .rd_idx    (rd_idx_s),
    .wr_hit    (wr_hit_s),
    .wr_onehot (wr_onehot_s),
    .wr_idx    (wr_idx_s),
    .free_any  (free_any_s),
    .free_idx  (free_idx_s)
  );

  // Ready comes straight from the registered count, so it is 1 during reset.
  assign alu_wr_ready = (count_q != FULL_CNT);
  assign out_pkt      = out_pkt_q;
  assign num_entries  = count_q;

  // Arbitrate write vs read, then build next slot contents, count and response.
  always_comb begin
    wr_fire_s   = alu_wr_valid & alu_wr_ready;
    same_addr_s = wr_fire_s && (alu_wr_addr == icon_req_addr);
    // A read colliding with a same-cycle write is a miss; the requester retries.
    rd_fire_s   = icon_req_valid & rd_hit_s & ~same_addr_s;
    // Free slot is taken from the current occupancy, so a slot freed this
    // cycle cannot be reused until the next one.
    alloc_s     = wr_fire_s & ~wr_hit_s & free_any_s;

    entries_d = entries_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      entries_d[i].occ  = (entries_q[i].occ & ~(rd_fire_s & rd_onehot_s[i])) |
                          (alloc_s & (free_idx_s == NUM_IDX_BITS'(i)));
      entries_d[i].addr = (alloc_s && (free_idx_s == NUM_IDX_BITS'(i))) ?
                          alu_wr_addr : entries_q[i].addr;
      entries_d[i].data = ((alloc_s && (free_idx_s == NUM_IDX_BITS'(i))) ||
                           (wr_fire_s && wr_hit_s && wr_onehot_s[i])) ?
                          alu_wr_data : entries_q[i].data;
    end

    count_d = count_q + (NUM_IDX_BITS+1)'(alloc_s) - (NUM_IDX_BITS+1)'(rd_fire_s);

    out_pkt_d       = out_pkt_q;
    out_pkt_d.valid = rd_fire_s;
    out_pkt_d.addr  = rd_fire_s ? icon_req_addr : out_pkt_q.addr;
    out_pkt_d.data  = rd_fire_s ? entries_q[rd_idx_s].data : out_pkt_q.data;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entries_q <= '0;
      count_q   <= '0;
      out_pkt_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      out_pkt_q <= out_pkt_d;
    end
  end

endmodule

// File: tb/tb_eu_txbuf.sv
// Randomised + directed bench for eu_txbuf against an address-keyed map model.
module tb_eu_txbuf;
  import pkg_dtypes::*;

  localparam int NIB = 2;
  localparam int CAP = 2**NIB;

  logic                clk = 1'b0;
  logic                reset;
  logic                alu_wr_valid;
  type_exec_unit_addr  alu_wr_addr;
  type_exec_unit_data  alu_wr_data;
  logic                alu_wr_ready;
  logic                icon_req_valid;
  type_exec_unit_addr  icon_req_addr;
  type_icon_tx_channel out_pkt;
  logic [NIB:0]        num_entries;

  always #5 clk = ~clk;

  eu_txbuf #(.NUM_IDX_BITS(NIB)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wr_valid   (alu_wr_valid),
    .alu_wr_addr    (alu_wr_addr),
    .alu_wr_data    (alu_wr_data),
    .alu_wr_ready   (alu_wr_ready),
    .icon_req_valid (icon_req_valid),
    .icon_req_addr  (icon_req_addr),
    .out_pkt        (out_pkt),
    .num_entries    (num_entries)
  );

  eu_txbuf_chk #(.NUM_IDX_BITS(NIB)) u_chk (
    .clk          (clk),
    .reset        (reset),
    .alu_wr_ready (alu_wr_ready),
    .num_entries  (num_entries)
  );

  // Model: the buffer content is just a map addr -> data with capacity CAP.
  type_exec_unit_data  m_map [type_exec_unit_addr];
  type_icon_tx_channel exp_pkt = '0;

  // Literal expectations pinned by the directed tests (checked at next negedge).
  logic                lit_pkt_en = 1'b0, lit_cnt_en = 1'b0, lit_rdy_en = 1'b0;
  type_icon_tx_channel lit_pkt;
  logic [NIB:0]        lit_cnt;
  logic                lit_rdy;

  int checks   = 0;
  int failures = 0;

  // Single compare process: model comparison every cycle, plus literal pins.
  always @(negedge clk) begin
    if (!reset) begin
      checks += 3;
      if (out_pkt !== exp_pkt) begin
        failures += 1;
        $display("FAIL model_pkt t=%0t actual=%h required=%h", $time, out_pkt, exp_pkt);
      end
      if (num_entries !== (NIB+1)'(m_map.size())) begin
        failures += 1;
        $display("FAIL model_count t=%0t actual=%0d required=%0d", $time, num_entries, m_map.size());
      end
      if (alu_wr_ready !== (m_map.size() != CAP)) begin
        failures += 1;
        $display("FAIL model_ready t=%0t actual=%b required=%b", $time, alu_wr_ready, m_map.size() != CAP);
      end
    end
    if (lit_pkt_en) begin
      checks += 1;
      if (out_pkt !== lit_pkt) begin
        failures += 1;
        $display("FAIL lit_pkt t=%0t actual=%h required=%h", $time, out_pkt, lit_pkt);
      end
    end
    if (lit_cnt_en) begin
      checks += 1;
      if (num_entries !== lit_cnt) begin
        failures += 1;
        $display("FAIL lit_count t=%0t actual=%0d required=%0d", $time, num_entries, lit_cnt);
      end
    end
    if (lit_rdy_en) begin
      checks += 1;
      if (alu_wr_ready !== lit_rdy) begin
        failures += 1;
        $display("FAIL lit_ready t=%0t actual=%b required=%b", $time, alu_wr_ready, lit_rdy);
      end
    end
  end

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic cycle(input logic wv, input logic [7:0] wa, input logic [15:0] wd,
                       input logic rv, input logic [7:0] ra);
    logic fire, hit;
    alu_wr_valid   = wv;
    alu_wr_addr    = wa;
    alu_wr_data    = wd;
    icon_req_valid = rv;
    icon_req_addr  = ra;
    @(posedge clk);
    lit_pkt_en = 1'b0;
    lit_cnt_en = 1'b0;
    lit_rdy_en = 1'b0;
    if (reset) begin
      m_map.delete();
      exp_pkt = '0;
    end else begin
      fire = wv && (m_map.size() != CAP);
      hit  = rv && m_map.exists(ra) && !(fire && (wa == ra));
      if (hit) begin
        exp_pkt = {1'b1, ra, m_map[ra]};
        m_map.delete(ra);
      end else begin
        exp_pkt.valid = 1'b0;
      end
      if (fire) m_map[wa] = wd;
    end
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 16'h0000, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    cycle(1'b1, a, d, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [7:0] a);
    cycle(1'b0, 8'h00, 16'h0000, 1'b1, a);
  endtask

  task automatic pin(input logic pe, input logic [24:0] p, input logic ce,
                     input logic [NIB:0] c, input logic re, input logic r);
    lit_pkt_en = pe;
    lit_pkt    = p;
    lit_cnt_en = ce;
    lit_cnt    = c;
    lit_rdy_en = re;
    lit_rdy    = r;
  endtask

  initial begin
    logic wv, rv;
    logic [7:0] wa, ra;
    reset          = 1'b1;
    alu_wr_valid   = 1'b0;
    alu_wr_addr    = 8'h00;
    alu_wr_data    = 16'h0000;
    icon_req_valid = 1'b0;
    icon_req_addr  = 8'h00;

    // Reset values while reset is held
    pin(1'b1, 25'h0, 1'b1, 3'd0, 1'b1, 1'b1);
    idle();
    idle();
    reset = 1'b0;
    idle();

    // Write then read, then a repeat read misses
    wr(8'h05, 16'h00AB);
    pin(1'b0, 25'h0, 1'b1, 3'd1, 1'b1, 1'b1);
    idle();
    rd(8'h05);
    pin(1'b1, {1'b1, 8'h05, 16'h00AB}, 1'b1, 3'd0, 1'b1, 1'b1);
    rd(8'h05);
    pin(1'b1, {1'b0, 8'h05, 16'h00AB}, 1'b1, 3'd0, 1'b0, 1'b0);
    idle();

    // Fill to full, blocked fifth write, read frees a slot, write completes
    for (int i = 1; i <= 4; i++) wr(8'(i), 16'h0100 + 16'(i));
    pin(1'b0, 25'h0, 1'b1, 3'd4, 1'b1, 1'b0);
    wr(8'h06, 16'h0066);
    pin(1'b0, 25'h0, 1'b1, 3'd4, 1'b1, 1'b0);
    cycle(1'b1, 8'h06, 16'h0066, 1'b1, 8'h02);
    pin(1'b1, {1'b1, 8'h02, 16'h0102}, 1'b1, 3'd3, 1'b1, 1'b1);
    wr(8'h06, 16'h0066);
    pin(1'b0, 25'h0, 1'b1, 3'd4, 1'b1, 1'b0);
    rd(8'h01);
    rd(8'h03);
    rd(8'h04);
    rd(8'h06);
    pin(1'b1, {1'b1, 8'h06, 16'h0066}, 1'b1, 3'd0, 1'b1, 1'b1);
    idle();

    // Overwrite keeps one entry and returns the newest data
    wr(8'h03, 16'h0011);
    wr(8'h03, 16'h0022);
    pin(1'b0, 25'h0, 1'b1, 3'd1, 1'b0, 1'b0);
    rd(8'h03);
    pin(1'b1, {1'b1, 8'h03, 16'h0022}, 1'b1, 3'd0, 1'b0, 1'b0);
    idle();

    // Same-address collision: read is a miss, write overwrites
    wr(8'h07, 16'h0010);
    cycle(1'b1, 8'h07, 16'h0020, 1'b1, 8'h07);
    pin(1'b1, {1'b0, 8'h03, 16'h0022}, 1'b1, 3'd1, 1'b0, 1'b0);
    rd(8'h07);
    pin(1'b1, {1'b1, 8'h07, 16'h0020}, 1'b1, 3'd0, 1'b0, 1'b0);
    idle();

    // Concurrent write and read hit on different addresses, then a miss
    wr(8'h01, 16'h0055);
    cycle(1'b1, 8'h02, 16'h0066, 1'b1, 8'h01);
    pin(1'b1, {1'b1, 8'h01, 16'h0055}, 1'b1, 3'd1, 1'b0, 1'b0);
    rd(8'h09);
    pin(1'b1, {1'b0, 8'h01, 16'h0055}, 1'b1, 3'd1, 1'b0, 1'b0);
    rd(8'h02);
    pin(1'b1, {1'b1, 8'h02, 16'h0066}, 1'b1, 3'd0, 1'b0, 1'b0);
    idle();

    // Asynchronous reset mid-operation takes effect before any clock edge
    wr(8'h04, 16'h0044);
    rd(8'h04);
    wr(8'h05, 16'h0045);
    #2;
    reset = 1'b1;
    pin(1'b1, 25'h0, 1'b1, 3'd0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    pin(1'b0, 25'h0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle();
    reset = 1'b0;
    idle();

    // Random traffic over a small address space to force hits, misses, full
    for (int n = 0; n < 3000; n++) begin
      wv = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 55);
      wa = 8'($urandom_range(0, 7));
      ra = ($urandom_range(0, 9) == 0) ? wa : 8'($urandom_range(0, 8));
      cycle(wv, wa, 16'($urandom), rv, ra);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eu_txbuf.md
Name: eu_txbuf

Overview:
Transmit-side result buffer of an execution unit; the counterpart of the EU receive buffer.
- The ALU pushes results tagged with their destination address.
- The interconnect pulls them by address and receives type_icon_tx_channel packets.
- Each entry is read-once: a successful interconnect read frees the slot.
- The block sits between the ALU writeback port and the interconnect TX channel.

Parameters:
NUM_IDX_BITS, 2, buffer depth = 2**NUM_IDX_BITS entries

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
alu_wr_valid  in  1  ALU result present
alu_wr_addr  in  $bits(type_exec_unit_addr)  destination address tag of result
alu_wr_data  in  $bits(type_exec_unit_data)  result value
alu_wr_ready  out  1  buffer can accept a write this cycle
icon_req_valid  in  1  interconnect read request present
icon_req_addr  in  $bits(type_exec_unit_addr)  address being requested
out_pkt  out  $bits(type_icon_tx_channel)  registered response {valid, addr, data}
num_entries  out  NUM_IDX_BITS+1  occupied-entry count, 0..2**NUM_IDX_BITS

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). The polarity and synchronicity are fixed.
- Storage: 2**NUM_IDX_BITS entries of {occ, addr, data}.
  - Invariant: at most one occupied entry per addr.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - all occ=0, num_entries=0
  - out_pkt=0 (valid=0)
  - alu_wr_ready=1 while reset is asserted and after it
- alu_wr_ready = (num_entries != 2**NUM_IDX_BITS); combinational from the registered count.
  - Full means ready=0, even when the write address matches an existing entry.
- A write fires when alu_wr_valid & alu_wr_ready.
  - If an occupied entry has addr == alu_wr_addr: overwrite its data, count unchanged.
  - Otherwise: allocate the lowest-index free entry and set occ=1, addr, data; count +1.
  - The write is visible to lookups from the next cycle.
- Read:
  - Combinational match of icon_req_addr against occupied entries.
  - Hit (and icon_req_valid):
    - next edge out_pkt = {1, icon_req_addr, stored data}
    - the matching entry's occ is cleared at the same edge; count -1
  - Miss: next edge out_pkt.valid=0 and no state change. The requester retries; no queueing.
  - Latency is exactly 1 cycle, request to out_pkt. out_pkt.valid is a single-cycle pulse per hit.
  - out_pkt.addr/data hold their last values when valid=0.
- Simultaneous write fire and read hit:
  - Different addresses: both are performed; net count change 0.
  - A freed slot is not reusable in the same cycle.
- Simultaneous write fire and read request to the same address:
  - The read is treated as a miss (out_pkt.valid=0 next cycle).
  - The write proceeds normally (overwrite or allocate).
  - The next read returns the new data.
- Write while full with alu_wr_valid=1: no state change; the ALU holds its data until ready.
- Count arithmetic is NUM_IDX_BITS+1 wide, with no wrap.
  - The count must never exceed 2**NUM_IDX_BITS or go below 0; this is asserted in simulation.

Decomposition:
- Shared package pkg_dtypes holds:
  - existing type_exec_unit_addr, type_exec_unit_data, type_icon_tx_channel
  - new packed typedef type_txbuf_entry {occ, addr, data}
- Sub-module eu_txbuf_lookup (purely combinational), parameterised by NUM_IDX_BITS. It provides:
  - a CAM match of one address against all occupied entries: hit flag plus one-hot/index
  - a second match port for the write address
  - a lowest-free-index priority encoder with an any-free flag
- eu_txbuf holds the entry registers, count, out_pkt register and the conflict logic.

Test Plan:
1. Reset then idle: assert reset asynchronously mid-cycle -> out_pkt.valid=0, num_entries=0, alu_wr_ready=1 immediately, without waiting for a clk edge.
2. Write then read: write (addr 0x05, data 0xAB) cycle 0, read addr 0x05 cycle 2 -> cycle 3 out_pkt={1,0x05,0xAB}, num_entries 1->0. A repeat read of 0x05 gets out_pkt.valid=0.
3. Fill to full: write addr 0x1..0x4 on consecutive cycles -> num_entries=4, alu_wr_ready=0. A fifth write (0x6) with valid held is not stored. Read 0x2 -> next cycle ready=1 and 0x6 is accepted the following cycle in slot 1 (lowest free).
4. Overwrite: write (0x3, 0x11), then (0x3, 0x22) -> num_entries=1. Read 0x3 returns 0x22.
5. Same-address collision: entry (0x7, 0x10) stored; in one cycle write (0x7, 0x20) and request 0x7 -> next cycle out_pkt.valid=0, count stays 1. Re-request -> {1, 0x7, 0x20}, count 0.
6. Concurrent different-address write and read hit, plus a read miss: stored 0x1; in one cycle write 0x2 and read 0x1 -> out_pkt={1,0x1,data}, count stays 1. Then read 0x9 -> out_pkt.valid=0, no state change.
